// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - in-flight destination tracker for the 5-stage pipeline.
// Status per register reflects the youngest pending producer among EX/MEM/WB slots.
module register_scoreboard #(
  parameter int NREG = 8,
  parameter int RW   = 3,
  parameter int SW   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_we_id,
  input  logic [RW-1:0]            issue_rd_id,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     hold,
  output logic [NREG-1:0][SW-1:0]  register_invalid,
  output logic [RW-1:0]            ex_rd,
  output logic [RW-1:0]            mem_rd,
  output logic [RW-1:0]            wb_rd,
  output logic                     ex_we,
  output logic                     mem_we,
  output logic                     wb_we
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_we  <= 1'b0;
      mem_we <= 1'b0;
      wb_we  <= 1'b0;
      ex_rd  <= '0;
      mem_rd <= '0;
      wb_rd  <= '0;
    end else if (!hold) begin
      wb_we <= mem_we;
      wb_rd <= mem_rd;
      // A flush squashes the instruction currently in EX before it reaches MEM.
      if (flush) begin
        mem_we <= 1'b0;
        mem_rd <= '0;
      end else begin
        mem_we <= ex_we;
        mem_rd <= ex_rd;
      end
      if (flush || stall) begin
        ex_we <= 1'b0;
        ex_rd <= '0;
      end else begin
        ex_we <= issue_we_id;
        ex_rd <= issue_rd_id;
      end
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_status
    localparam logic [RW-1:0] RIDX = RW'(r);
    assign register_invalid[r] = (ex_we  && ex_rd  == RIDX) ? SW'(3) :
                                 (mem_we && mem_rd == RIDX) ? SW'(2) :
                                 (wb_we  && wb_rd  == RIDX) ? SW'(1) : SW'(0);
  end

endmodule

// File: tb/tb_register_scoreboard.sv
// tb/tb_register_scoreboard.sv - randomized check of register_scoreboard against an age-list model.
module tb_register_scoreboard;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_we_id = 1'b0;
  logic [2:0]       issue_rd_id = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             hold = 1'b0;
  logic [7:0][2:0]  register_invalid;
  logic [2:0]       ex_rd, mem_rd, wb_rd;
  logic             ex_we, mem_we, wb_we;

  int n_vec  = 0;
  int n_miss = 0;

  // Pending writes as (destination, age); age 0 = EX, 1 = MEM, 2 = WB.
  int pend_rd[$];
  int pend_age[$];

  register_scoreboard #(.NREG(8), .RW(3), .SW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_we_id(issue_we_id), .issue_rd_id(issue_rd_id),
    .stall(stall), .flush(flush), .hold(hold),
    .register_invalid(register_invalid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_status();
    logic [23:0] v = '0;
    for (int r = 0; r < 8; r++) begin
      int best = 3;
      for (int i = 0; i < pend_rd.size(); i++)
        if (pend_rd[i] == r && pend_age[i] < best) best = pend_age[i];
      v[r*3 +: 3] = 3'(3 - best);
    end
    return v;
  endfunction

  function automatic int rd_at(input int age);
    for (int i = 0; i < pend_rd.size(); i++)
      if (pend_age[i] == age) return pend_rd[i];
    return -1;
  endfunction

  task automatic compare_all(input string tag);
    int rx, rm, rw;
    rx = rd_at(0); rm = rd_at(1); rw = rd_at(2);
    check({tag, ".status"}, 32'(register_invalid), 32'(exp_status()));
    check({tag, ".we"}, {29'd0, ex_we, mem_we, wb_we},
          {29'd0, rx >= 0, rm >= 0, rw >= 0});
    if (rx >= 0) check({tag, ".ex_rd"},  32'(ex_rd),  32'(rx));
    if (rm >= 0) check({tag, ".mem_rd"}, 32'(mem_rd), 32'(rm));
    if (rw >= 0) check({tag, ".wb_rd"},  32'(wb_rd),  32'(rw));
  endtask

  task automatic model_edge(input logic we, input logic [2:0] rd, input logic st, input logic fl,
                            input logic hd);
    if (hd) return;
    for (int i = pend_rd.size() - 1; i >= 0; i--) begin
      if ((fl && pend_age[i] == 0) || pend_age[i] == 2) begin
        pend_rd.delete(i);
        pend_age.delete(i);
      end else begin
        pend_age[i]++;
      end
    end
    if (we && !st && !fl) begin
      pend_rd.push_back(int'(rd));
      pend_age.push_back(0);
    end
  endtask

  task automatic cycle(input logic we, input logic [2:0] rd, input logic st, input logic fl,
                       input logic hd, input string tag);
    issue_we_id = we; issue_rd_id = rd; stall = st; flush = fl; hold = hd;
    @(posedge clk);
    model_edge(we, rd, st, fl, hd);
    #1;
    compare_all(tag);
  endtask

  // Reset asserted between edges must clear everything without a clock.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    pend_rd.delete();
    pend_age.delete();
    compare_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    pend_rd.delete(); pend_age.delete();
    compare_all("reset");
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    compare_all("post_reset");

    // single producer walks 3,2,1,0
    cycle(1, 3'd5, 0, 0, 0, "s1_issue");
    cycle(0, 3'd0, 0, 0, 0, "s1_mem");
    cycle(0, 3'd0, 0, 0, 0, "s1_wb");
    cycle(0, 3'd0, 0, 0, 0, "s1_done");

    // back-to-back to the same register, youngest wins
    cycle(1, 3'd2, 0, 0, 0, "s2_a");
    cycle(1, 3'd2, 0, 0, 0, "s2_b");
    for (int k = 0; k < 3; k++) cycle(0, 3'd0, 0, 0, 0, "s2_drain");

    // stall inserts a bubble, ID re-presented
    cycle(1, 3'd4, 0, 0, 0, "s3_issue");
    cycle(1, 3'd6, 1, 0, 0, "s3_stall");
    cycle(1, 3'd6, 0, 0, 0, "s3_release");
    for (int k = 0; k < 3; k++) cycle(0, 3'd0, 0, 0, 0, "s3_drain");

    // flush squashes ID and EX, MEM advances to WB
    cycle(1, 3'd7, 0, 0, 0, "s4_old");
    cycle(1, 3'd3, 0, 0, 0, "s4_victim");
    cycle(1, 3'd1, 1, 1, 0, "s4_flush");
    for (int k = 0; k < 2; k++) cycle(0, 3'd0, 0, 0, 0, "s4_drain");

    // hold freezes all slots regardless of stall/flush
    cycle(1, 3'd1, 0, 0, 0, "s5_f1");
    cycle(1, 3'd2, 0, 0, 0, "s5_f2");
    cycle(1, 3'd3, 0, 0, 0, "s5_f3");
    for (int k = 0; k < 4; k++)
      cycle(1, 3'(k), k[0], k[1], 1, "s5_hold");
    for (int k = 0; k < 3; k++) cycle(0, 3'd0, 0, 0, 0, "s5_resume");

    // asynchronous reset with slots loaded, then recovery
    cycle(1, 3'd0, 0, 0, 0, "s6_l1");
    cycle(1, 3'd6, 0, 0, 0, "s6_l2");
    async_reset("s6_async");
    cycle(1, 3'd5, 0, 0, 0, "s6_issue");
    cycle(0, 3'd0, 0, 0, 0, "s6_mem");

    for (int k = 0; k < 400; k++) begin
      logic we, st, fl, hd;
      we = 1'($urandom_range(0, 3) != 0);
      st = 1'($urandom_range(0, 5) == 0);
      fl = 1'($urandom_range(0, 7) == 0);
      hd = 1'($urandom_range(0, 6) == 0);
      cycle(we, 3'($urandom_range(0, 7)), st, fl, hd, "rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
